// File: rtl/axis_read_sched.sv
// rtl/axis_read_sched.sv - descriptor queue and config-bus sequencer for axis_read
// Optional AXIS_READ_SCHED_STATS_EN adds jobs_done / beats_total counters.
module axis_read_sched #(
  parameter int CONFIG_ID     = 1,
  parameter int CONFIG_ADDR   = 23,
  parameter int CONFIG_DATA   = 24,
  parameter int CONFIG_AWIDTH = 5,
  parameter int CONFIG_DWIDTH = 32,
  parameter int QUEUE_AWIDTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CONFIG_DWIDTH-1:0] desc_addr,
  input  logic [CONFIG_DWIDTH-1:0] desc_len,
  input  logic                     desc_valid,
  output logic                     desc_ready,
  output logic [CONFIG_AWIDTH-1:0] cfg_addr,
  output logic [CONFIG_DWIDTH-1:0] cfg_data,
  output logic                     cfg_valid,
  input  logic                     mon_valid,
  input  logic                     mon_ready,
  output logic                     busy,
  output logic                     done
`ifdef AXIS_READ_SCHED_STATS_EN
  ,output logic [CONFIG_DWIDTH-1:0] jobs_done
  ,output logic [CONFIG_DWIDTH-1:0] beats_total
`endif
);

  localparam int DEPTH = 1 << QUEUE_AWIDTH;
  localparam logic [QUEUE_AWIDTH:0]  PTR_ONE = 1;
  localparam logic [CONFIG_DWIDTH-1:0] ONE = 1;

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_ID   = 6'b000010,
    S_ADDR = 6'b000100,
    S_LEN  = 6'b001000,
    S_RUN  = 6'b010000,
    S_DONE = 6'b100000
  } state_t;

  state_t state, state_next;

  logic [QUEUE_AWIDTH:0]          wr_ptr, rd_ptr;
  logic [2*CONFIG_DWIDTH-1:0]     mem [DEPTH];
  logic                           full, empty, push, pop, beat;
  logic [CONFIG_DWIDTH-1:0]       job_addr, job_len, remaining;
  logic                           cfg_valid_d;
  logic [CONFIG_AWIDTH-1:0]       cfg_addr_d;
  logic [CONFIG_DWIDTH-1:0]       cfg_data_d;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[QUEUE_AWIDTH] != rd_ptr[QUEUE_AWIDTH]) &&
                      (wr_ptr[QUEUE_AWIDTH-1:0] == rd_ptr[QUEUE_AWIDTH-1:0]);
  assign desc_ready = !rst && !full;
  assign push       = desc_valid && desc_ready;
  assign beat       = mon_valid && mon_ready;
  assign busy       = (state != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (!empty) state_next = S_ID;
      S_ID:   state_next = S_ADDR;
      S_ADDR: state_next = S_LEN;
      S_LEN:  state_next = (job_len == '0) ? S_DONE : S_RUN;
      S_RUN:  if (beat && remaining == ONE) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // cfg words are computed from the upcoming state so they register into the cycle that state is active
  always_comb begin
    pop         = (state == S_IDLE) && !empty;
    done        = (state == S_DONE);
    cfg_valid_d = 1'b0;
    cfg_addr_d  = cfg_addr;
    cfg_data_d  = cfg_data;
    unique case (state_next)
      S_ID: begin
        cfg_valid_d = 1'b1;
        cfg_addr_d  = CONFIG_AWIDTH'(CONFIG_ADDR);
        cfg_data_d  = CONFIG_DWIDTH'(CONFIG_ID);
      end
      S_ADDR: begin
        cfg_valid_d = 1'b1;
        cfg_addr_d  = CONFIG_AWIDTH'(CONFIG_DATA);
        cfg_data_d  = job_addr;
      end
      S_LEN: begin
        cfg_valid_d = 1'b1;
        cfg_addr_d  = CONFIG_AWIDTH'(CONFIG_DATA);
        cfg_data_d  = job_len;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[QUEUE_AWIDTH-1:0]] <= {desc_addr, desc_len};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      job_addr  <= '0;
      job_len   <= '0;
      remaining <= '0;
      cfg_valid <= 1'b0;
      cfg_addr  <= '0;
      cfg_data  <= '0;
    end else begin
      cfg_valid <= cfg_valid_d;
      cfg_addr  <= cfg_addr_d;
      cfg_data  <= cfg_data_d;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        {job_addr, job_len} <= mem[rd_ptr[QUEUE_AWIDTH-1:0]];
      end
      if (state == S_LEN)
        remaining <= job_len;
      else if (state == S_RUN && beat)
        remaining <= remaining - ONE;
    end
  end

`ifdef AXIS_READ_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      jobs_done   <= '0;
      beats_total <= '0;
    end else begin
      if (state == S_DONE)        jobs_done   <= jobs_done + ONE;
      if (state == S_RUN && beat) beats_total <= beats_total + ONE;
    end
  end
`endif

endmodule

// File: tb/tb_axis_read_sched.sv
// tb/tb_axis_read_sched.sv - directed table-driven bench for axis_read_sched
module tb_axis_read_sched;

  logic        clk, rst;
  logic [31:0] desc_addr, desc_len;
  logic        desc_valid, desc_ready;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_valid, mon_valid, mon_ready, busy, done;
`ifdef AXIS_READ_SCHED_STATS_EN
  logic [31:0] jobs_done, beats_total;
`endif

  axis_read_sched dut (
    .clk(clk), .rst(rst),
    .desc_addr(desc_addr), .desc_len(desc_len),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .mon_valid(mon_valid), .mon_ready(mon_ready),
    .busy(busy), .done(done)
`ifdef AXIS_READ_SCHED_STATS_EN
    ,.jobs_done(jobs_done), .beats_total(beats_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [36:0] MARK = {5'h1f, 32'h0000_d0de};
  logic [36:0] log_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (cfg_valid) log_q.push_back({cfg_addr, cfg_data});
      if (done)      log_q.push_back(MARK);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
    int          stall_at;
    int          stall_len;
    int          exp_done;
  } vec_t;

  vec_t tbl[4];
  logic [31:0] a_addr[6];
  logic [31:0] a_len[6];

  initial begin
    bit stall, accepted;
    int ndone;

    tbl[0] = '{32'h1000_0000, 32'd8, 0, 0, 13};
    tbl[1] = '{32'h2000_0040, 32'd0, 0, 0, 5};
    tbl[2] = '{32'h0000_0100, 32'd4, 7, 10, 19};
    tbl[3] = '{32'hffff_fffc, 32'd1, 0, 0, 6};
    a_addr = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500, 32'h600};
    a_len  = '{32'd2, 32'd1, 32'd3, 32'd0, 32'd2, 32'd1};

    rst = 1'b1; desc_valid = 1'b0; desc_addr = '0; desc_len = '0;
    mon_valid = 1'b0; mon_ready = 1'b0;
    repeat (3) tick();
    check("rst_cfg_valid", cfg_valid, 0);
    check("rst_cfg_addr", cfg_addr, 0);
    check("rst_cfg_data", cfg_data, 0);
    check("rst_desc_ready", desc_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", desc_ready, 1);

    // table: one job at a time, beats offered every cycle except during a stall window
    for (int j = 0; j < 4; j++) begin
      for (int c = 0; c <= tbl[j].exp_done + 1; c++) begin
        stall = (c >= tbl[j].stall_at) && (c < tbl[j].stall_at + tbl[j].stall_len);
        mon_ready  = !stall;
        mon_valid  = stall ? c[0] : 1'b1;
        desc_valid = (c == 0);
        desc_addr  = tbl[j].addr;
        desc_len   = tbl[j].len;
        if (c == 0) check("desc_ready", desc_ready, 1);
        if (c == 1) check("busy_queued", busy, 1);
        if (c == 2) begin
          check("id_valid", cfg_valid, 1);
          check("id_addr", cfg_addr, 23);
          check("id_data", cfg_data, 1);
        end
        if (c == 3) begin
          check("addr_valid", cfg_valid, 1);
          check("addr_addr", cfg_addr, 24);
          check("addr_data", cfg_data, tbl[j].addr);
        end
        if (c == 4) begin
          check("len_valid", cfg_valid, 1);
          check("len_addr", cfg_addr, 24);
          check("len_data", cfg_data, tbl[j].len);
        end
        if (c == 1 || c >= 5) check("cfg_valid_low", cfg_valid, 0);
        if (c == 5) check("cfg_data_hold", cfg_data, tbl[j].len);
        check("done", done, c == tbl[j].exp_done);
        if (c == tbl[j].exp_done + 1) check("busy_end", busy, 0);
        tick();
      end
    end
    desc_valid = 1'b0;
`ifdef AXIS_READ_SCHED_STATS_EN
    check("jobs_done", jobs_done, 4);
    check("beats_total", beats_total, 13);
`endif

    // fill the queue behind a job that is stuck in S_RUN
    log_q.delete();
    mon_valid = 1'b0; mon_ready = 1'b0;
    desc_valid = 1'b1; desc_addr = a_addr[0]; desc_len = a_len[0];
    tick();
    desc_valid = 1'b0;
    repeat (5) tick();
    for (int i = 1; i <= 4; i++) begin
      desc_valid = 1'b1; desc_addr = a_addr[i]; desc_len = a_len[i];
      check("fill_ready", desc_ready, 1);
      tick();
    end
    desc_addr = a_addr[5]; desc_len = a_len[5];
    check("full", desc_ready, 0);
    repeat (3) begin
      tick();
      check("full_hold", desc_ready, 0);
    end
    mon_valid = 1'b1; mon_ready = 1'b1;
    accepted = 1'b0;
    ndone = 0;
    for (int k = 0; k < 50 && !accepted; k++) begin
      if (desc_ready) begin
        accepted = 1'b1;
        foreach (log_q[n]) if (log_q[n] == MARK) ndone++;
      end
      tick();
    end
    desc_valid = 1'b0;
    check("push5_accepted", accepted, 1);
    check("push5_after_first_done", ndone, 1);
    for (int k = 0; k < 400 && busy; k++) tick();
    check("fifo_drained", busy, 0);
    check("log_size", log_q.size(), 24);
    if (log_q.size() == 24) begin
      for (int i = 0; i < 6; i++) begin
        check("order_id", log_q[4*i], {5'd23, 32'd1});
        check("order_addr", log_q[4*i+1], {5'd24, a_addr[i]});
        check("order_len", log_q[4*i+2], {5'd24, a_len[i]});
        check("order_done", log_q[4*i+3], MARK);
      end
    end

    // reset during S_ADDR with a second job queued
    mon_valid = 1'b0; mon_ready = 1'b0;
    desc_valid = 1'b1; desc_addr = 32'haaaa_0000; desc_len = 32'd5;
    tick();
    desc_addr = 32'hbbbb_0000; desc_len = 32'd3;
    tick();
    desc_valid = 1'b0;
    tick();
    check("pre_rst_addr_valid", cfg_valid, 1);
    check("pre_rst_addr_data", cfg_data, 32'haaaa_0000);
    rst = 1'b1;
    tick();
    check("abort_cfg_valid", cfg_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_desc_ready", desc_ready, 0);
    check("abort_done", done, 0);
    tick();
    rst = 1'b0;
    log_q.delete();
    mon_valid = 1'b1; mon_ready = 1'b1;
    repeat (10) begin
      tick();
      check("quiet_done", done, 0);
    end
    check("quiet_log", log_q.size(), 0);
    check("quiet_busy", busy, 0);
    desc_valid = 1'b1; desc_addr = 32'hcccc_0000; desc_len = 32'd0;
    tick();
    desc_valid = 1'b0;
    repeat (8) tick();
    check("new_job_log_size", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check("new_job_addr", log_q[1], {5'd24, 32'hcccc_0000});
      check("new_job_done", log_q[3], MARK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
